// File: rtl/sys_mem_resp.sv
// sys_mem_resp: single-port 16-bit memory with fixed-latency reads; ports Clk1/Reset, Addr/RD/WR/DataIn in, DataOut/Valid/Busy/Err out
module sys_mem_resp #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 2
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Valid,
  output logic        Busy,
  output logic        Err
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RWAIT  = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);
  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_dout;
  logic        r_valid;
  logic        r_err;
  logic [15:0] r_mem [0:(1 << DEPTH_LOG2) - 1];
  logic        w_idle;
  logic        w_in_range;
  logic        w_lat_in_range;
  logic        w_rd_acc;
  logic        w_wr_acc;
  logic        w_done;
  assign w_idle         = r_state == IDLE;
  assign w_in_range     = (Addr >> DEPTH_LOG2) == 16'd0;
  assign w_lat_in_range = (r_addr >> DEPTH_LOG2) == 16'd0;
  assign w_rd_acc       = w_idle && RD && !WR;
  assign w_wr_acc       = w_idle && WR && !RD && w_in_range;
  assign w_done         = !w_idle && r_cnt == 4'd0;
  assign DataOut        = r_dout;
  assign Valid          = r_valid;
  assign Err            = r_err;
  assign Busy           = r_state == RWAIT;
  always_ff @(posedge Clk1)
    if (!Reset && w_wr_acc) r_mem[Addr[DEPTH_LOG2-1:0]] <= DataIn;
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 16'd0;
      r_dout  <= 16'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_done;
      r_err   <= w_idle ? (RD && WR) || (WR && !RD && !w_in_range)
                        : RD || WR || (w_done && !w_lat_in_range);
      if (w_rd_acc) begin
        r_state <= RWAIT;
        r_cnt   <= LAT_M1;
        r_addr  <= Addr;
      end else if (w_done) begin
        r_state <= IDLE;
        r_dout  <= w_lat_in_range ? r_mem[r_addr[DEPTH_LOG2-1:0]] : 16'h0000;
      end else if (!w_idle) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_sys_mem_resp.sv
// tb_sys_mem_resp: directed bench with a cycle-level reference model and literal spot checks
module tb_sys_mem_resp;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Addr = 16'd0;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [15:0] DataIn = 16'd0;
  logic [15:0] DataOut;
  logic        Valid;
  logic        Busy;
  logic        Err;
  int          total = 0;
  int          passed = 0;
  sys_mem_resp #(.DEPTH_LOG2(8), .READ_LAT(LAT)) dut (
    .Clk1(clk), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
    .DataOut(DataOut), .Valid(Valid), .Busy(Busy), .Err(Err)
  );
  always #5 clk = ~clk;
  logic [15:0] mm [0:DEPTH-1];
  logic        armed = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_dout = 16'd0;
  logic [15:0] m_addr = 16'd0;
  int          e = 0;
  int          m_done = 0;
  int          vq[$];
  always @(posedge clk) begin
    e <= e + 1;
    if (Reset) begin
      armed   <= 1'b1;
      m_busy  <= 1'b0;
      m_dout  <= 16'd0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_valid <= m_busy && e == m_done;
      m_err   <= m_busy ? (RD || WR || (e == m_done && int'(m_addr) >= DEPTH))
                        : ((RD && WR) || (WR && !RD && int'(Addr) >= DEPTH));
      if (m_busy && e == m_done) begin
        m_busy <= 1'b0;
        m_dout <= int'(m_addr) < DEPTH ? mm[m_addr[7:0]] : 16'd0;
      end
      if (!m_busy && RD && !WR) begin
        m_busy <= 1'b1;
        m_addr <= Addr;
        m_done <= e + LAT;
      end
      if (!m_busy && WR && !RD && int'(Addr) < DEPTH) mm[Addr[7:0]] <= DataIn;
    end
  end
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at edge %0d", n, act, exp, e);
    else passed++;
  endtask
  always @(negedge clk) if (armed) begin
    chk("model_dout", DataOut, m_dout);
    chk("model_valid", {15'd0, Valid}, {15'd0, m_valid});
    chk("model_busy", {15'd0, Busy}, {15'd0, m_busy});
    chk("model_err", {15'd0, Err}, {15'd0, m_err});
    if (Valid === 1'b1) vq.push_back(e);
  end
  task automatic cyc(input logic rst, input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    Reset = rst; RD = rd; WR = wr; Addr = a; DataIn = d;
    @(negedge clk);
    Reset = 1'b0; RD = 1'b0; WR = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask
  task automatic read_expect(input string n, input logic [15:0] a, input logic [15:0] exp);
    cyc(1'b0, 1'b1, 1'b0, a, 16'd0);
    idle(LAT);
    chk({n, "_valid"}, {15'd0, Valid}, 16'd1);
    chk({n, "_data"}, DataOut, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("reset_dout", DataOut, 16'h0000);
    chk("reset_flags", {13'd0, Valid, Busy, Err}, 16'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i), 16'h1000 + 16'(i));
    chk("write_no_valid", {15'd0, Valid}, 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 16'd0);
    chk("wr_rd_busy1", {15'd0, Busy}, 16'd1);
    idle(1);
    chk("wr_rd_busy2", {15'd0, Busy}, 16'd1);
    idle(1);
    chk("wr_rd_busy_end", {15'd0, Busy}, 16'd0);
    chk("wr_rd_valid", {15'd0, Valid}, 16'd1);
    chk("wr_rd_data", DataOut, 16'hBEEF);
    chk("wr_rd_err", {15'd0, Err}, 16'd0);
    idle(1);
    chk("valid_one_cycle", {15'd0, Valid}, 16'd0);
    chk("dout_hold", DataOut, 16'hBEEF);
    cyc(1'b0, 1'b0, 1'b1, 16'h0100, 16'h1234);
    chk("oor_wr_err", {15'd0, Err}, 16'd1);
    idle(1);
    chk("oor_wr_err_once", {15'd0, Err}, 16'd0);
    read_expect("oor_alias", 16'h0000, 16'h1000);
    cyc(1'b0, 1'b1, 1'b0, 16'h0100, 16'd0);
    idle(LAT);
    chk("oor_rd_flags", {14'd0, Valid, Err}, 16'd3);
    chk("oor_rd_data", DataOut, 16'h0000);
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0005, 16'hDEAD);
    chk("coll_flags", {13'd0, Valid, Busy, Err}, 16'd1);
    idle(1);
    read_expect("coll_mem", 16'h0005, 16'h1005);
    cyc(1'b0, 1'b1, 1'b0, 16'h0001, 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0001, 16'hFFFF);
    chk("busy_wr_err", {15'd0, Err}, 16'd1);
    idle(1);
    chk("busy_wr_valid", {15'd0, Valid}, 16'd1);
    chk("busy_wr_data", DataOut, 16'h1001);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0002, 16'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'd0);
    chk("rst_mid_flags", {13'd0, Valid, Busy, Err}, 16'd0);
    chk("rst_mid_dout", DataOut, 16'h0000);
    idle(3);
    chk("rst_mid_no_valid", {15'd0, Valid}, 16'd0);
    read_expect("rst_mid_mem", 16'h0002, 16'h1002);
    idle(2);
    vq.delete();
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      cyc(1'b0, 1'b1, 1'b0, 16'(i), 16'd0);
      while (Busy === 1'b1 && n < 20) begin
        idle(1);
        n++;
      end
      chk("tp_wait_bound", 16'(n < 20), 16'd1);
      chk("tp_valid", {15'd0, Valid}, 16'd1);
      chk("tp_data", DataOut, 16'h1000 + 16'(i));
    end
    idle(1);
    chk("tp_count", 16'(vq.size()), 16'd4);
    for (int i = 1; i < vq.size(); i++) chk("tp_spacing", 16'(vq[i] - vq[i-1]), 16'd3);
    cyc(1'b1, 1'b1, 1'b1, 16'h0003, 16'hFFFF);
    cyc(1'b1, 1'b1, 1'b0, 16'h0003, 16'd0);
    chk("rst_ignore_busy", {15'd0, Busy}, 16'd0);
    read_expect("rst_ignore_mem", 16'h0003, 16'h1003);
    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sys_mem_resp.md
SYS_MEM_RESP -- requirements
Module: sys_mem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, SHALL set storage to 2^DEPTH_LOG2 words of 16 bits.
REQ-002 Parameter READ_LAT, default 2, legal range 1..15, SHALL set read latency in Clk1 cycles.
REQ-003 Clk1  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Addr  input  16  word address from the initiator.
REQ-006 RD  input  1  read request, sampled on the rising edge of Clk1.
REQ-007 WR  input  1  write request, sampled on the rising edge of Clk1.
REQ-008 DataIn  input  16  write data from the initiator.
REQ-009 DataOut  output  16  registered read data returned to the initiator.
REQ-010 Valid  output  1  one-cycle pulse marking DataOut as new read data.
REQ-011 Busy  output  1  high while a read is in flight; new requests are not accepted.
REQ-012 Err  output  1  one-cycle pulse flagging a rejected or out-of-range request.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and RWAIT, plus a 4-bit latency counter.
REQ-014 Busy SHALL be 1 exactly when the state is RWAIT.
REQ-015 In IDLE, an edge with WR=1, RD=0 and in-range Addr SHALL write DataIn to mem[Addr[DEPTH_LOG2-1:0]] at that edge; the state SHALL stay IDLE and no Valid SHALL be produced.
REQ-016 Addr is in range iff Addr[15:DEPTH_LOG2]==0; an out-of-range write SHALL be dropped and Err SHALL pulse in the following cycle.
REQ-017 In IDLE, an edge N with RD=1, WR=0 SHALL latch Addr, load the counter with READ_LAT-1 and enter RWAIT.
REQ-018 In RWAIT, each edge with counter!=0 SHALL decrement the counter.
REQ-019 In RWAIT, the edge with counter==0 (edge N+READ_LAT) SHALL load DataOut from mem at the latched address, set Valid=1 for one cycle and return to IDLE.
REQ-020 A read of an out-of-range latched address SHALL return DataOut=16'h0000, with Err and Valid pulsing in the same cycle.
REQ-021 RD=1 and WR=1 on the same edge in IDLE SHALL perform no access, SHALL not change state and SHALL pulse Err in the following cycle.
REQ-022 RD or WR asserted on any edge while in RWAIT SHALL be ignored (no memory change, no state change) and SHALL pulse Err in the following cycle.
REQ-023 DataOut SHALL hold its last value between reads; Valid and Err SHALL be 0 in every cycle not named above.
REQ-024 A new request SHALL be accepted at edge N+READ_LAT+1, so back-to-back reads SHALL complete every READ_LAT+1 cycles.
REQ-025 A read accepted one edge after a write to the same address SHALL return the newly written data.
REQ-026 Memory SHALL be a single-port, 16-bit wide, synchronous-write array; the read data path SHALL be registered only into DataOut.

Reset
REQ-027 Reset=1 at an edge SHALL force the state to IDLE, the counter to 0, DataOut=16'h0000, and Valid, Busy and Err to 0.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 Reset during RWAIT SHALL abort the read; no Valid SHALL follow.
REQ-030 RD and WR SHALL be ignored on any edge where Reset=1.

Verification (DEPTH_LOG2=8, READ_LAT=2)
REQ-031 Write then read: WR at Addr=16'h0010 with DataIn=16'hBEEF, then RD at Addr=16'h0010 on the next edge -> Busy is high for 2 cycles, then DataOut=16'hBEEF with a single Valid pulse and Err=0.
REQ-032 Out of range: WR at Addr=16'h0100 with DataIn=16'h1234 -> Err pulses once; a later read of 16'h0000 returns its prior contents; RD at 16'h0100 -> DataOut=0 with Valid and Err pulsing together.
REQ-033 Collision: RD=WR=1 at Addr=16'h0005 -> no state change, mem[5] unchanged, Err pulses once, Valid=0.
REQ-034 Request during Busy: RD at 16'h0001, then WR with DataIn=16'hFFFF at 16'h0001 on the next edge -> the write is ignored with an Err pulse, and the read returns the original mem[1].
REQ-035 Reset mid-read: RD accepted, then Reset=1 on the following edge -> Busy=0, Valid never asserts and DataOut=0; a subsequent read of that address returns its pre-reset contents.
REQ-036 Throughput: 4 back-to-back reads of addresses 0..3, each issued when Busy=0 -> 4 Valid pulses spaced 3 cycles apart, each with the correct data.
